// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the stride-2 max-pooling engine.
package cnn_pool_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} pool_state_e;

  localparam int unsigned MAX_DW = 64;

  function automatic int unsigned out_w(input int unsigned img_w);
    return img_w / 2;
  endfunction

  function automatic int unsigned out_h(input int unsigned img_h);
    return img_h / 2;
  endfunction

  // Returns 1 when b is strictly greater than a over the low w bits; operands are
  // shifted so their sign bit lands in the MSB, making one signed compare work for any w.
  function automatic logic max_sel(input logic [MAX_DW-1:0] a, input logic [MAX_DW-1:0] b,
                                   input int unsigned w, input logic is_signed);
    logic [MAX_DW-1:0] sa;
    logic [MAX_DW-1:0] sb;
    sa = a << (MAX_DW - w);
    sb = b << (MAX_DW - w);
    if (is_signed) return $signed(sb) > $signed(sa);
    return sb > sa;
  endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// One row of horizontal pair maxima, held until the matching odd row arrives.
module maxpool_line_buf #(
  parameter int unsigned DEPTH = 13,
  parameter int unsigned WIDTH = 128,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pooling engine: raster-reads a stored map, pools all channels
// in parallel and writes pooled pixels with their destination address.
module maxpool2x2_stream
  import cnn_pool_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned IMG_W    = 26,
  parameter int unsigned IMG_H    = 26,
  parameter int unsigned SIGNED   = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pause,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            rd_row,
  output logic [ADDR_W-1:0]            rd_col,
  input  logic [CHANNELS*DATA_W-1:0]   rd_data,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_row,
  output logic [ADDR_W-1:0]            out_col,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         done_early
);

  localparam int unsigned OW    = out_w(IMG_W);
  localparam int unsigned OH    = out_h(IMG_H);
  localparam int unsigned PW    = CHANNELS * DATA_W;
  localparam int unsigned IDX_W = (OW > 1) ? $clog2(OW) : 1;
  localparam bit          DE_EN = (OH >= 2);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] COL_LIM   = ADDR_W'(2 * OW);
  localparam logic [ADDR_W-1:0] ROW_LIM   = ADDR_W'(2 * OH);
  localparam logic [ADDR_W-1:0] DE_ROW    = ADDR_W'(DE_EN ? OH - 2 : 0);
  localparam logic [ADDR_W-1:0] LAST_OCOL = ADDR_W'(OW - 1);

  pool_state_e       state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic              drain_q, drain_d;
  logic              issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        row_d   = '0;
        col_d   = '0;
      end
      READ: if (!pause) begin
        issue = 1'b1;
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            drain_d = 1'b0;
            state_d = DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_en  = issue;
  assign rd_row = row_q;
  assign rd_col = col_q;
  assign busy   = (state_q == READ) || (state_q == DRAIN);
  assign done   = (state_q == DONE);

  // Tag stage: row/col of the read whose data is on rd_data this cycle.
  logic              v1_q;
  logic [ADDR_W-1:0] r1_q, c1_q;
  logic [PW-1:0]     hold_q, hmax, vmax, lb_rdata;
  logic              px_ok, lb_we, emit;
  logic [IDX_W-1:0]  lb_idx;
  logic              ov_q, de_q;
  logic [ADDR_W-1:0] orow_q, ocol_q;
  logic [PW-1:0]     od_q;

  assign px_ok  = v1_q && (c1_q < COL_LIM) && (r1_q < ROW_LIM);
  assign lb_idx = IDX_W'(c1_q >> 1);
  assign lb_we  = px_ok && c1_q[0] && !r1_q[0];
  assign emit   = px_ok && c1_q[0] && r1_q[0];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DATA_W-1:0] held, cur, prev, hm;
    assign held = hold_q[gi*DATA_W +: DATA_W];
    assign cur  = rd_data[gi*DATA_W +: DATA_W];
    assign prev = lb_rdata[gi*DATA_W +: DATA_W];
    assign hm   = max_sel(MAX_DW'(held), MAX_DW'(cur), DATA_W, SIGNED != 0) ? cur : held;
    assign hmax[gi*DATA_W +: DATA_W] = hm;
    assign vmax[gi*DATA_W +: DATA_W] =
      max_sel(MAX_DW'(prev), MAX_DW'(hm), DATA_W, SIGNED != 0) ? hm : prev;
  end

  maxpool_line_buf #(
    .DEPTH (OW),
    .WIDTH (PW),
    .IDX_W (IDX_W)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_idx),
    .wdata_i (hmax),
    .raddr_i (lb_idx),
    .rdata_o (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      r1_q   <= '0;
      c1_q   <= '0;
      hold_q <= '0;
      ov_q   <= 1'b0;
      de_q   <= 1'b0;
      orow_q <= '0;
      ocol_q <= '0;
      od_q   <= '0;
    end else begin
      v1_q <= issue;
      r1_q <= row_q;
      c1_q <= col_q;
      if (px_ok && !c1_q[0]) hold_q <= rd_data;
      ov_q <= emit;
      de_q <= emit && DE_EN && ((r1_q >> 1) == DE_ROW) && ((c1_q >> 1) == LAST_OCOL);
      if (emit) begin
        orow_q <= r1_q >> 1;
        ocol_q <= c1_q >> 1;
        od_q   <= vmax;
      end
    end
  end

  assign out_valid  = ov_q;
  assign out_row    = orow_q;
  assign out_col    = ocol_q;
  assign out_data   = od_q;
  assign done_early = de_q;

endmodule
